md_sequencer: RTL and testbench

Multiply/divide sequencer for the five-stage MIPS pipeline. It owns the HI/LO registers and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage. It models fixed multi-cycle latency with a busy counter and raises a stall request toward the hazard unit when a D-stage instruction needs the unit while it is occupied.

---
 rtl/md_pkg.sv | 28 ++
 rtl/md_arith.sv | 59 +++++
 rtl/md_sequencer.sv | 82 ++++++++
 tb/tb_md_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared encodings and constants for the multiply/divide sequencer.
//   Op encodings MD_MULT..MD_MTLO (3 bits), counter width MD_CNT_W,
//   MD_INT_MIN / MD_NEG_ONE for the signed-overflow division case,
//   and helpers that classify an op as a multiply or a divide.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdOp_e;

  localparam int          MD_CNT_W   = 4;
  localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;
  localparam logic [31:0] MD_NEG_ONE = 32'hFFFF_FFFF;

  function automatic logic mdIsMul(input logic [2:0] op);
    return op == MD_MULT || op == MD_MULTU;
  endfunction

  function automatic logic mdIsDiv(input logic [2:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath.
//   op     in  3   operation (md_pkg encodings)
//   a, b   in  32  rs / rt operands
//   resHi  out 32  product high word, or remainder
//   resLo  out 32  product low word, or quotient
//   div0   out 1   divide op with b == 0
// The divider exists only when MD_DIV_EN is defined; otherwise the
// result is always the product and div0 is tied low.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] resHi,
  output logic [31:0] resLo,
  output logic        div0
);

  logic [63:0] prod;

  // Sign- or zero-extend to 64 bits so the low 64 bits of the product are
  // exact for both signednesses.
  always_comb
    prod = op == MD_MULT ? {{32{a[31]}}, a} * {{32{b[31]}}, b}
                         : {32'b0, a} * {32'b0, b};

`ifdef MD_DIV_EN
  logic        divSgn, aNeg, bNeg, isDiv, ovf;
  logic [31:0] aMag, bMag, den, uq, ur, q, r;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend.
  always_comb begin
    isDiv  = mdIsDiv(op);
    divSgn = op == MD_DIV;
    aNeg   = divSgn & a[31];
    bNeg   = divSgn & b[31];
    aMag   = aNeg ? -a : a;
    bMag   = bNeg ? -b : b;
    den    = bMag == 32'd0 ? 32'd1 : bMag;
    uq     = aMag / den;
    ur     = aMag % den;
    ovf    = divSgn && a == MD_INT_MIN && b == MD_NEG_ONE;
    q      = ovf ? MD_INT_MIN : (aNeg ^ bNeg) ? -uq : uq;
    r      = ovf ? 32'd0 : aNeg ? -ur : ur;
    resHi  = isDiv ? r : prod[63:32];
    resLo  = isDiv ? q : prod[31:0];
    div0   = isDiv && b == 32'd0;
  end
`else
  always_comb begin
    resHi = prod[63:32];
    resLo = prod[31:0];
    div0  = 1'b0;
  end
`endif

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: HI/LO owner with fixed-latency multiply/divide sequencing.
//   clk       in  1   clock, rising edge
//   rst_n     in  1   asynchronous active-low reset
//   start     in  1   E-stage md op valid this cycle
//   op        in  3   md_pkg op encoding
//   a, b      in  32  forwarded rs / rt operands
//   md_use_d  in  1   D-stage instruction uses the md unit
//   busy      out 1   operation in flight
//   stall_md  out 1   stall request to the hazard unit
//   hi, lo    out 32  architectural HI / LO
// Define MD_DIV_EN to include DIV/DIVU; without it they act as undefined ops.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [MD_CNT_W-1:0] cnt;
  logic [31:0]         pendHi, pendLo, resHi, resLo;
  logic                pendDiv0, resDiv0, isMul, isDiv;

  md_arith uArith (
    .op   (op),
    .a    (a),
    .b    (b),
    .resHi(resHi),
    .resLo(resLo),
    .div0 (resDiv0)
  );

  assign isMul = mdIsMul(op);
`ifdef MD_DIV_EN
  assign isDiv = mdIsDiv(op);
`else
  assign isDiv = 1'b0;
`endif

  assign busy     = cnt != '0;
  // start term covers the issue cycle, before busy has risen.
  assign stall_md = md_use_d & (start | busy);

  // cnt is the whole state: zero is idle, nonzero counts down to the commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pendHi   <= '0;
      pendLo   <= '0;
      pendDiv0 <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (busy) begin
      cnt <= cnt - MD_CNT_W'(1);
      if (cnt == MD_CNT_W'(1) && !pendDiv0) begin
        hi <= pendHi;
        lo <= pendLo;
      end
    end else if (start) begin
      if (isMul || isDiv) begin
        pendHi   <= resHi;
        pendLo   <= resLo;
        pendDiv0 <= isDiv & resDiv0;
        cnt      <= isMul ? MD_CNT_W'(MULT_CYCLES) : MD_CNT_W'(DIV_CYCLES);
      end
      if (op == MD_MTHI) hi <= a;
      if (op == MD_MTLO) lo <= a;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: scoreboard bench for md_sequencer (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_sequencer;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        md_use_d = 1'b0;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] expQ[$];
  logic prevBusy = 1'b0;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .md_use_d(md_use_d), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The hazard unit never issues while the unit is occupied.
  always @(posedge clk)
    if (rst_n) assert (!(start && busy));

  // Monitor: each busy falling edge is a commit; compare HI/LO to the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      prevBusy = 1'b0;
    end else begin
      if (prevBusy && !busy) begin
        if (expQ.size() == 0) chk("unexpected_commit", {hi, lo}, 64'hx);
        else chk("commit_hilo", {hi, lo}, expQ.pop_front());
      end
      prevBusy = busy;
    end
  end

  // Issue one op and check busy/stall across its whole occupancy.
  task automatic runOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic useD, input int n, input bit timed, input logic [63:0] exp);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; md_use_d = useD;
    if (timed) expQ.push_back(exp);
    @(negedge clk);
    chk("busy_issue", busy, 1'b0);
    chk("stall_issue", stall_md, useD);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk("busy_run", busy, 1'b1);
      chk("stall_run", stall_md, useD);
    end
    @(negedge clk);
    chk("busy_done", busy, 1'b0);
    chk("stall_done", stall_md, 1'b0);
    md_use_d = 1'b0;
  endtask

  task automatic mtOp(input logic [2:0] o, input logic [31:0] v);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = v;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("mt_busy", busy, 1'b0);
    chk(o == MD_MTHI ? "mthi" : "mtlo", o == MD_MTHI ? hi : lo, v);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_hilo", {hi, lo}, 64'h0);
    chk("post_rst_stall", stall_md, 1'b0);

    mtOp(MD_MTHI, 32'd5);
    mtOp(MD_MTLO, 32'd9);

    runOp(MD_MULT,  32'hFFFF_FFFD, 32'd7,        1'b1, MC, 1, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp(MD_MULTU, 32'hFFFF_FFFF, 32'd2,        1'b0, MC, 1, 64'h0000_0001_FFFF_FFFE);
    runOp(MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MC, 1, 64'h0000_0000_0000_0001);
    runOp(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, MC, 1, 64'hFFFF_FFFE_0000_0001);
    runOp(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, MC, 1, 64'h4000_0000_0000_0000);

`ifdef MD_DIV_EN
    runOp(MD_DIVU, 32'd100,       32'd7,         1'b0, DC, 1, 64'h0000_0002_0000_000E);
    runOp(MD_DIV,  32'hFFFF_FFF9, 32'd2,         1'b1, DC, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC, 1, 64'h0000_0000_8000_0000);
    mtOp(MD_MTHI, 32'd5);
    mtOp(MD_MTLO, 32'd9);
    runOp(MD_DIV,  32'd123,       32'd0,         1'b1, DC, 1, 64'h0000_0005_0000_0009);
    runOp(MD_DIVU, 32'd77,        32'd0,         1'b0, DC, 1, 64'h0000_0005_0000_0009);
    chk("div0_hilo", {hi, lo}, 64'h0000_0005_0000_0009);
`else
    runOp(MD_DIVU, 32'd100, 32'd7, 1'b0, 0, 0, 64'h0);
    repeat (2) @(negedge clk);
    chk("nodiv_busy", busy, 1'b0);
    chk("nodiv_hilo", {hi, lo}, 64'h4000_0000_0000_0000);
    runOp(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, MC, 1, 64'h0000_0001_FFFF_FFFE);
`endif

    mtOp(MD_MTHI, 32'h1234_5678);
    mtOp(MD_MTLO, 32'h9ABC_DEF0);
    runOp(3'd6, 32'hDEAD_BEEF, 32'd3, 1'b1, 0, 0, 64'h0);
    runOp(3'd7, 32'hDEAD_BEEF, 32'd3, 1'b0, 0, 0, 64'h0);
    chk("undef_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

    // Reset two cycles into a MULT: abort, clear, and never commit.
    @(posedge clk); #1;
    start = 1'b1; op = MD_MULT; a = 32'd6; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_commit_busy", busy, 1'b0);
    chk("abort_no_commit_hilo", {hi, lo}, 64'h0);

    chk("scoreboard_drain", 64'(expQ.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
